controle_desvio: RTL and testbench
==================================

# controle_desvio

Program-counter and jump sequencer for the 16-bit multi-cycle core. It owns the PC register and the ALU flag register, and it advances the PC on fetch. It also evaluates and executes the jump family (instrucao[15:14]==00): jump false, jump true, unconditional jump, jump-and-link and jump-register. It sits beside the main control FSM, which issues `incrementa` during fetch and `executa` during execute, and it drives the ROM address and the register-bank link write.

## Interface
Parameters:
- LARGURA_PC, 16: PC and target width. The ROM address is pc[LARGURA_PC-1:0].
- ENDERECO_RESET, 16'h0000: PC value after reset.
- REG_LINK, 3'd7: register-bank index written by jump-and-link.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; asserting it forces every register to its reset value immediately.
- instrucao  in  16  current instruction, held stable by the main controller from fetch until `concluido`.
- incrementa  in  1  one-cycle fetch pulse: pc <= pc+1.
- executa  in  1  one-cycle pulse: start jump evaluation of `instrucao`.
- flags_in  in  5  ALU flags: [0] zero, [1] negativo, [2] carry, [3] overflow, [4] negativo|zero.
- flags_we  in  1  load flags_in into the flag register.
- reg_dado  in  16  register-bank port A read data, valid one cycle after `reg_sel` changes.
- pc  out  16  program counter; reset = ENDERECO_RESET.
- reg_sel  out  3  register-bank port A select for jump-register; reset 0.
- link_dado  out  16  return address; reset 0.
- link_sel  out  3  link destination, constant REG_LINK.
- link_we  out  1  one-cycle link write strobe; reset 0.
- ocupado  out  1  high from the cycle after `executa` until `concluido`; reset 0.
- concluido  out  1  one-cycle completion pulse; reset 0.
- desvio_tomado  out  1  valid with `concluido`: 1 = PC loaded with the target; reset 0.
- contador_desvios  out  16  taken-jump count (see Configuration); reset 0.

## Operation
Decode fields, latched at `executa`:
- tipo = [13:12]
- cond_sel = [10:8]
- JF/JT offset = sext([7:0])
- J offset = sext([11:0])
- JAL offset = sext([10:0]), selected when [13:12]==11 and [11]==0
- JR source register = [2:0], selected when [13:12]==11 and [11]==1

Conditions:
- cond = flag_reg[cond_sel] for cond_sel 0..4; cond_sel 5..7 gives cond = 1.
- JF is taken when cond==0; JT is taken when cond==1; J, JAL and JR are always taken.

Target arithmetic:
- target = pc_base + offset, computed modulo 2^16 with wrap-around in both directions.
- pc_base = pc at the `executa` cycle, i.e. the already-incremented return address.
- JR target = reg_dado, not sign-processed.

FSM:
- OCIOSO: on `executa`, latch instrucao and pc_base, then go to DECODIFICA.
- DECODIFICA:
  - If instrucao[15:14]!=00, go to ATUALIZA with no jump.
  - JR: drive reg_sel=[2:0] and go to LE_REG.
  - Otherwise compute target and taken, then go to ATUALIZA.
- LE_REG: capture reg_dado as target, taken=1, go to ATUALIZA.
- ATUALIZA:
  - If taken, pc <= target.
  - Pulse `concluido`; `desvio_tomado` = taken.
  - For JAL, pulse `link_we` with link_dado = pc_base.
  - Go to OCIOSO.

Boundary rules:
- `executa` while ocupado is ignored.
- `incrementa` is ignored while ocupado or while `executa` is asserted in the same cycle.
- If `flags_we` and `executa` arrive in the same cycle, evaluation uses the old flag value; the flag register still updates.
- `flags_we` is accepted in every state.
- Reset mid-operation aborts to OCIOSO and suppresses any pending link write or PC load.
- pc+1 wraps from 16'hFFFF to 16'h0000.

## Timing
- `executa` in cycle 0: DECODIFICA in cycle 1, ATUALIZA in cycle 2.
  - `concluido` and `link_we` are high during cycle 2.
  - The new pc is visible in cycle 3.
- JR adds LE_REG:
  - reg_sel is valid from cycle 1.
  - `concluido` is high in cycle 3; the new pc is visible in cycle 4.
- `incrementa` in cycle n: pc+1 is visible in cycle n+1.
- All outputs are registered; none is combinational from an input.

## Configuration
- CONTROLE_DESVIO_CONTADOR_EN defined:
  - `contador_desvios` increments by one in every ATUALIZA cycle with taken=1.
  - It saturates at 16'hFFFF and clears on reset.
- Not defined: `contador_desvios` is tied to 0 and no counter register is synthesized.

## Test plan
- Reset release, then 3 `incrementa` pulses -> pc = 0x0003. Assert reset mid-count -> pc = 0x0000 asynchronously.
- flags_we with flags_in=5'b00001, pc=0x0010, JT instrucao=16'h1000|8'hFC (cond_sel 0, offset -4), `executa` -> concluido in cycle 2 with desvio_tomado=1, pc=0x000C in cycle 3. The same instruction as JF (0x00FC) -> desvio_tomado=0, pc stays 0x0010.
- pc=0x0005, JAL with offset 11'h7FF (-1) -> link_we pulse with link_dado=0x0005 and link_sel=7; pc=0x0004.
- JR instrucao=16'h3803, reg_dado=0xABCD presented in cycle 2 -> reg_sel=3 in cycle 1, concluido in cycle 3, pc=0xABCD in cycle 4.
- pc=0xFFFE, unconditional J offset +4 -> pc=0x0002 (wrap). `executa` and `incrementa` together -> only the jump takes effect. A second `executa` while ocupado is ignored.
- Macro defined: 3 taken jumps and 1 not-taken jump -> contador_desvios=3. Macro undefined -> contador_desvios=0.

Source files
------------

// File: rtl/controle_desvio.sv
// rtl/controle_desvio.sv - PC register, flag register and jump-family sequencer (JF/JT/J/JAL/JR).
// Optional taken-jump counter enabled by defining CONTROLE_DESVIO_CONTADOR_EN.
module controle_desvio #(
  parameter int                    LARGURA_PC     = 16,
  parameter logic [LARGURA_PC-1:0] ENDERECO_RESET = '0,
  parameter logic [2:0]            REG_LINK       = 3'd7
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [15:0]           instrucao,
  input  logic                  incrementa,
  input  logic                  executa,
  input  logic [4:0]            flags_in,
  input  logic                  flags_we,
  input  logic [15:0]           reg_dado,
  output logic [LARGURA_PC-1:0] pc,
  output logic [2:0]            reg_sel,
  output logic [LARGURA_PC-1:0] link_dado,
  output logic [2:0]            link_sel,
  output logic                  link_we,
  output logic                  ocupado,
  output logic                  concluido,
  output logic                  desvio_tomado,
  output logic [15:0]           contador_desvios
);

  typedef enum logic [1:0] {OCIOSO, DECODIFICA, LE_REG, ATUALIZA} estado_t;

  estado_t               estado_q, estado_d;
  logic [LARGURA_PC-1:0] pc_q, pc_d, base_q, base_d, alvo_q, alvo_d, link_dado_q, link_dado_d;
  logic [15:0]           instr_q, instr_d;
  logic [4:0]            flags_q, flags_d;
  logic [2:0]            reg_sel_q, reg_sel_d;
  logic                  cond_q, cond_d, tomado_q, tomado_d;
  logic                  link_we_q, link_we_d, ocupado_q, ocupado_d;
  logic                  concluido_q, concluido_d, desvio_q, desvio_d;
  logic [7:0]            cond_vet;
  logic                  eh_salto, eh_jal, eh_jr;

  // Condition is sampled at the executa edge so a same-cycle flags_we cannot affect it
  assign cond_vet = {3'b111, flags_q};
  assign eh_salto = (instr_q[15:14] == 2'b00);
  assign eh_jal   = eh_salto && (instr_q[13:12] == 2'b11) && !instr_q[11];
  assign eh_jr    = eh_salto && (instr_q[13:12] == 2'b11) && instr_q[11];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado_q <= OCIOSO;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:     if (executa) estado_d = DECODIFICA;
      DECODIFICA: estado_d = eh_jr ? LE_REG : ATUALIZA;
      LE_REG:     estado_d = ATUALIZA;
      ATUALIZA:   estado_d = OCIOSO;
      default:    estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    pc_d        = pc_q;
    base_d      = base_q;
    alvo_d      = alvo_q;
    instr_d     = instr_q;
    cond_d      = cond_q;
    tomado_d    = tomado_q;
    reg_sel_d   = reg_sel_q;
    link_dado_d = link_dado_q;
    flags_d     = flags_we ? flags_in : flags_q;

    if (estado_q == ATUALIZA && tomado_q)
      pc_d = alvo_q;
    else if (estado_q == OCIOSO && incrementa && !executa)
      pc_d = pc_q + 1'b1;

    if (estado_q == OCIOSO && executa) begin
      instr_d = instrucao;
      base_d  = pc_q;
      cond_d  = cond_vet[instrucao[10:8]];
      if (instrucao[15:11] == 5'b00111) reg_sel_d = instrucao[2:0];
    end

    if (estado_q == DECODIFICA) begin
      tomado_d = 1'b0;
      if (eh_salto) begin
        case (instr_q[13:12])
          2'b00: begin
            alvo_d   = base_q + LARGURA_PC'($signed(instr_q[7:0]));
            tomado_d = !cond_q;
          end
          2'b01: begin
            alvo_d   = base_q + LARGURA_PC'($signed(instr_q[7:0]));
            tomado_d = cond_q;
          end
          2'b10: begin
            alvo_d   = base_q + LARGURA_PC'($signed(instr_q[11:0]));
            tomado_d = 1'b1;
          end
          default: begin
            alvo_d   = base_q + LARGURA_PC'($signed(instr_q[10:0]));
            tomado_d = !instr_q[11];
          end
        endcase
      end
    end else if (estado_q == LE_REG) begin
      alvo_d   = LARGURA_PC'(reg_dado);
      tomado_d = 1'b1;
    end

    // Pulses are registered one state ahead so they line up with the ATUALIZA cycle
    concluido_d = (estado_d == ATUALIZA);
    desvio_d    = (estado_d == ATUALIZA) && tomado_d;
    link_we_d   = (estado_d == ATUALIZA) && eh_jal;
    ocupado_d   = (estado_d != OCIOSO);
    if (link_we_d) link_dado_d = base_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q        <= ENDERECO_RESET;
      base_q      <= '0;
      alvo_q      <= '0;
      instr_q     <= '0;
      flags_q     <= '0;
      cond_q      <= 1'b0;
      tomado_q    <= 1'b0;
      reg_sel_q   <= '0;
      link_dado_q <= '0;
      link_we_q   <= 1'b0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
      desvio_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      base_q      <= base_d;
      alvo_q      <= alvo_d;
      instr_q     <= instr_d;
      flags_q     <= flags_d;
      cond_q      <= cond_d;
      tomado_q    <= tomado_d;
      reg_sel_q   <= reg_sel_d;
      link_dado_q <= link_dado_d;
      link_we_q   <= link_we_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
      desvio_q    <= desvio_d;
    end
  end

`ifdef CONTROLE_DESVIO_CONTADOR_EN
  logic [15:0] cont_q, cont_d;

  always_comb begin
    cont_d = cont_q;
    if (estado_q == ATUALIZA && tomado_q && cont_q != 16'hFFFF) cont_d = cont_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cont_q <= '0;
    else        cont_q <= cont_d;
  end

  assign contador_desvios = cont_q;
`else
  assign contador_desvios = '0;
`endif

  assign pc            = pc_q;
  assign reg_sel       = reg_sel_q;
  assign link_dado     = link_dado_q;
  assign link_sel      = REG_LINK;
  assign link_we       = link_we_q;
  assign ocupado       = ocupado_q;
  assign concluido     = concluido_q;
  assign desvio_tomado = desvio_q;

endmodule

// File: tb/tb_controle_desvio.sv
// tb/tb_controle_desvio.sv - table-driven scoreboard bench for controle_desvio.
module tb_controle_desvio;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instrucao = '0;
  logic        incrementa = 1'b0;
  logic        executa = 1'b0;
  logic [4:0]  flags_in = '0;
  logic        flags_we = 1'b0;
  logic [15:0] reg_dado = '0;
  logic [15:0] pc, link_dado, contador_desvios;
  logic [2:0]  reg_sel, link_sel;
  logic        link_we, ocupado, concluido, desvio_tomado;

  controle_desvio dut (
    .clock(clock), .reset(reset), .instrucao(instrucao), .incrementa(incrementa),
    .executa(executa), .flags_in(flags_in), .flags_we(flags_we), .reg_dado(reg_dado),
    .pc(pc), .reg_sel(reg_sel), .link_dado(link_dado), .link_sel(link_sel),
    .link_we(link_we), .ocupado(ocupado), .concluido(concluido),
    .desvio_tomado(desvio_tomado), .contador_desvios(contador_desvios)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] rd;
    logic        pre_fw;
    logic        same_fw;
    logic [4:0]  fl;
    logic        incr;
    logic        taken;
    logic [15:0] pc;
    logic        lw;
    logic [15:0] ld;
    int          lat;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [15:0] pc;
    logic        lw;
    logic [15:0] ld;
    int          lat;
  } exp_t;

  vec_t v[15];
  exp_t sb[$];
  int   nvec = 0;
  int   nfail = 0;
  int   ntaken = 0;

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    nvec++;
    if (atual !== esperado) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nome, atual, esperado);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] cnt_esperado();
`ifdef CONTROLE_DESVIO_CONTADOR_EN
    return (ntaken > 65535) ? 16'hFFFF : 16'(ntaken);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic aplica(input vec_t x);
    exp_t e;
    int   n;
    if (x.pre_fw) begin
      flags_in = x.fl; flags_we = 1'b1;
      step();
      flags_we = 1'b0;
    end
    instrucao = x.instr; reg_dado = x.rd; executa = 1'b1; incrementa = x.incr;
    if (x.same_fw) begin flags_in = x.fl; flags_we = 1'b1; end
    sb.push_back('{x.taken, x.pc, x.lw, x.ld, x.lat});
    step();
    executa = 1'b0; incrementa = 1'b0; flags_we = 1'b0;
    chk("ocupado_c1", ocupado, 1'b1);
    if (x.instr[15:11] == 5'b00111) chk("reg_sel_c1", reg_sel, x.instr[2:0]);
    n = 1;
    while (!concluido && n < 8) begin step(); n++; end
    if (!concluido) chk("concluido_timeout", 0, 1);
    e = sb.pop_front();
    chk("latencia", n, e.lat);
    chk("desvio_tomado", desvio_tomado, e.taken);
    chk("link_we", link_we, e.lw);
    if (e.lw) begin
      chk("link_dado", link_dado, e.ld);
      chk("link_sel", link_sel, 3'd7);
    end
    if (e.taken) ntaken++;
    step();
    chk("pc", pc, e.pc);
    chk("concluido_1ciclo", concluido, 1'b0);
    chk("ocupado_fim", ocupado, 1'b0);
    chk("contador", contador_desvios, cnt_esperado());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    v[0]  = '{16'h3803, 16'h0010, 0, 0, 5'h00, 0, 1, 16'h0010, 0, 16'h0000, 3};
    v[1]  = '{16'h10FC, 16'h0000, 1, 0, 5'h01, 0, 1, 16'h000C, 0, 16'h0000, 2};
    v[2]  = '{16'h3803, 16'h0010, 0, 0, 5'h00, 0, 1, 16'h0010, 0, 16'h0000, 3};
    v[3]  = '{16'h00FC, 16'h0000, 0, 0, 5'h00, 0, 0, 16'h0010, 0, 16'h0000, 2};
    v[4]  = '{16'h3805, 16'h0005, 0, 0, 5'h00, 0, 1, 16'h0005, 0, 16'h0000, 3};
    v[5]  = '{16'h37FF, 16'h0000, 0, 0, 5'h00, 0, 1, 16'h0004, 1, 16'h0005, 2};
    v[6]  = '{16'h3801, 16'hFFFE, 0, 0, 5'h00, 0, 1, 16'hFFFE, 0, 16'h0000, 3};
    v[7]  = '{16'h2004, 16'h0000, 0, 0, 5'h00, 1, 1, 16'h0002, 0, 16'h0000, 2};
    v[8]  = '{16'h10FC, 16'h0000, 0, 1, 5'h00, 0, 1, 16'hFFFE, 0, 16'h0000, 2};
    v[9]  = '{16'h00FC, 16'h0000, 0, 0, 5'h00, 0, 1, 16'hFFFA, 0, 16'h0000, 2};
    v[10] = '{16'h4000, 16'h0000, 0, 0, 5'h00, 0, 0, 16'hFFFA, 0, 16'h0000, 2};
    v[11] = '{16'h1502, 16'h0000, 0, 0, 5'h00, 0, 1, 16'hFFFC, 0, 16'h0000, 2};
    v[12] = '{16'h0701, 16'h0000, 0, 0, 5'h00, 0, 0, 16'hFFFC, 0, 16'h0000, 2};
    v[13] = '{16'h2FFF, 16'h0000, 0, 0, 5'h00, 0, 1, 16'hFFFB, 0, 16'h0000, 2};
    v[14] = '{16'h1401, 16'h0000, 1, 0, 5'h10, 0, 1, 16'hFFFC, 0, 16'h0000, 2};

    // Reset state
    step(); step();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ocupado", ocupado, 1'b0);
    chk("rst_concluido", concluido, 1'b0);
    chk("rst_link_we", link_we, 1'b0);
    chk("rst_link_dado", link_dado, 16'h0000);
    chk("rst_reg_sel", reg_sel, 3'd0);
    chk("rst_contador", contador_desvios, 16'h0000);
    reset = 1'b1;
    step();

    incrementa = 1'b1;
    step(); step(); step();
    incrementa = 1'b0;
    chk("incr_3", pc, 16'h0003);
    incrementa = 1'b1;
    step(); step();
    chk("incr_5", pc, 16'h0005);
    #2 reset = 1'b0;
    #1 chk("reset_assincrono", pc, 16'h0000);
    incrementa = 1'b0;
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 15; i++) aplica(v[i]);

    // Second executa and incrementa while busy are both ignored
    instrucao = 16'h2001; executa = 1'b1;
    step();
    instrucao = 16'h2010; incrementa = 1'b1;
    step();
    executa = 1'b0; incrementa = 1'b0;
    chk("ign_concluido_c2", concluido, 1'b1);
    chk("ign_desvio", desvio_tomado, 1'b1);
    ntaken++;
    step();
    chk("ign_pc", pc, 16'hFFFD);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (concluido) n++;
    end
    chk("ign_sem_segundo_concluido", n, 0);
    chk("ign_pc_final", pc, 16'hFFFD);
    chk("ign_contador", contador_desvios, cnt_esperado());

    // Reset during a JAL aborts before ATUALIZA
    instrucao = 16'h37FF; executa = 1'b1;
    step();
    executa = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("abort_ocupado", ocupado, 1'b0);
    chk("abort_pc", pc, 16'h0000);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (link_we || concluido) n++;
    end
    chk("abort_sem_pulsos", n, 0);
    reset = 1'b1;
    ntaken = 0;
    step(); step();
    chk("abort_pc_final", pc, 16'h0000);
    chk("abort_contador", contador_desvios, cnt_esperado());

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
